// File: rtl/soft_deinterleaver.sv
// soft_deinterleaver: 802.11a soft-decision block deinterleaver, ping-pong banks with valid/ready on both sides
module soft_deinterleaver #(
   parameter int SOFT_W    = 4,
   parameter int MAX_NCBPS = 288
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              flush,
   input  logic [1:0]        mode,
   input  logic [SOFT_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [SOFT_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic [1:0]        out_mode
);
   localparam int AW = $clog2(MAX_NCBPS);
   typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_t;

   function automatic logic [9:0] ncbps(input logic [1:0] m);
      return m == 2'd0 ? 10'd48 : m == 2'd1 ? 10'd96 : m == 2'd2 ? 10'd192 : 10'd288;
   endfunction

   function automatic logic [9:0] ncol(input logic [1:0] m);
      return m == 2'd0 ? 10'd3 : m == 2'd1 ? 10'd6 : m == 2'd2 ? 10'd12 : 10'd18;
   endfunction

   bank_t             st [2];
   bank_t             st_n [2];
   logic [1:0]        bmode [2];
   logic [SOFT_W-1:0] mem [2][MAX_NCBPS];
   logic              wsel, rsel, dsel, rdy_en;
   logic [9:0]        wcnt, rk, wn, rn, ri, rj, j2, j3;
   logic              wr, wlast, issue, rlast, pop;
   logic              v1, v2, l1, l2, b1;
   logic [1:0]        m1, m2;
   logic [AW-1:0]     a1;
   logic [SOFT_W-1:0] d2;
   logic [SOFT_W+2:0] q [3];
   logic [1:0]        fcnt, widx;
   logic [2:0]        occ;

   assign in_ready  = rdy_en && (st[wsel] == EMPTY || st[wsel] == FILLING);
   assign wr        = in_valid && in_ready && !flush;
   assign wn        = ncbps(st[wsel] == EMPTY ? mode : bmode[wsel]);
   assign wlast     = wcnt == wn - 10'd1;
   assign out_valid = fcnt != 2'd0;
   assign out_data  = q[0][SOFT_W-1:0];
   assign out_mode  = q[0][SOFT_W+1:SOFT_W];
   assign out_last  = q[0][SOFT_W+2] && out_valid;
   assign pop       = out_valid && out_ready;
   assign widx      = fcnt - {1'b0, pop};
   // Items in flight plus buffered never exceed the 3-entry output queue
   assign occ       = {2'd0, v1} + {2'd0, v2} + {1'b0, fcnt};
   assign issue     = (st[rsel] == FULL || st[rsel] == DRAINING) && (occ < 3'd3 || pop);
   assign rn        = ncbps(bmode[rsel]);
   assign rlast     = rk == rn - 10'd1;
   assign ri        = ncol(bmode[rsel]) * {6'd0, rk[3:0]} + {4'd0, rk[9:4]};
   assign j2        = 10'd2 * (ri / 10'd2) + (ri + 10'd192 - ri / 10'd12) % 10'd2;
   assign j3        = 10'd3 * (ri / 10'd3) + (ri + 10'd288 - ri / 10'd18) % 10'd3;
   assign rj        = bmode[rsel][1] ? (bmode[rsel][0] ? j3 : j2) : ri;

   always_comb begin
      for (int b = 0; b < 2; b++) begin
         st_n[b] = st[b];
         if (wr && wsel == 1'(b))
            st_n[b] = wlast ? FULL : FILLING;
         if (flush && wsel == 1'(b) && st[b] == FILLING)
            st_n[b] = EMPTY;
         if (issue && rsel == 1'(b) && st[b] == FULL)
            st_n[b] = DRAINING;
         if (pop && out_last && dsel == 1'(b))
            st_n[b] = EMPTY;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         st[0] <= EMPTY;
         st[1] <= EMPTY;
      end else begin
         st[0] <= st_n[0];
         st[1] <= st_n[1];
      end
   end

   always_ff @(posedge clock) begin
      if (wr)
         mem[wsel][AW'(wcnt)] <= in_data;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rdy_en   <= 1'b0;
         wsel     <= 1'b0;
         rsel     <= 1'b0;
         dsel     <= 1'b0;
         wcnt     <= '0;
         rk       <= '0;
         bmode[0] <= '0;
         bmode[1] <= '0;
         v1       <= 1'b0;
         l1       <= 1'b0;
         m1       <= '0;
         b1       <= 1'b0;
         a1       <= '0;
         v2       <= 1'b0;
         l2       <= 1'b0;
         m2       <= '0;
         d2       <= '0;
         fcnt     <= '0;
         for (int i = 0; i < 3; i++)
            q[i] <= '0;
      end else begin
         rdy_en <= 1'b1;
         if (wr) begin
            if (st[wsel] == EMPTY)
               bmode[wsel] <= mode;
            wcnt <= wlast ? 10'd0 : wcnt + 10'd1;
            if (wlast)
               wsel <= ~wsel;
         end else if (flush)
            wcnt <= '0;
         v1 <= issue;
         if (issue) begin
            a1   <= AW'(rj);
            l1   <= rlast;
            m1   <= bmode[rsel];
            b1   <= rsel;
            rk   <= rlast ? 10'd0 : rk + 10'd1;
            rsel <= rsel ^ rlast;
         end
         v2 <= v1;
         l2 <= l1;
         m2 <= m1;
         d2 <= mem[b1][a1];
         if (pop)
            for (int i = 0; i < 2; i++)
               q[i] <= q[i+1];
         if (v2)
            q[widx] <= {l2, m2, d2};
         fcnt <= fcnt + {1'b0, v2} - {1'b0, pop};
         if (pop && out_last)
            dsel <= ~dsel;
      end
   end
endmodule

// File: tb/tb_soft_deinterleaver.sv
// tb_soft_deinterleaver: randomized stimulus against a permutation-table reference model
module tb_soft_deinterleaver;
   localparam int W = 9;

   logic         clock = 0, reset = 0, flush = 0, in_valid = 0, out_ready = 0;
   logic [1:0]   mode = 0;
   logic [W-1:0] in_data = 0;
   logic         in_ready, out_valid, out_last;
   logic [W-1:0] out_data;
   logic [1:0]   out_mode;

   soft_deinterleaver #(.SOFT_W(W), .MAX_NCBPS(288)) dut (
      .clock(clock), .reset(reset), .flush(flush), .mode(mode),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .out_mode(out_mode)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      logic [W-1:0] d;
      logic         l;
      logic [1:0]   m;
   } ent_t;

   ent_t expq[$];
   int   cap[$];
   int   lastcyc[$];
   int   npass = 0, ntot = 0, nout = 0, rdy_pct = 100, rise_cyc = -1, acc_cyc = 0;
   bit   stalled = 0, prev_v = 0;
   logic [W-1:0] hd;
   logic         hl;
   logic [1:0]   hm;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      ntot++;
      if (got === exp) npass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // Transmit interleaver rule: output k of the deinterleaver is received bit perm(k)
   function automatic int perm(input int m, input int k);
      int nb = m == 0 ? 1 : m == 1 ? 2 : m == 2 ? 4 : 6;
      int n  = 48 * nb;
      int s  = nb / 2 > 1 ? nb / 2 : 1;
      int i  = (n / 16) * (k % 16) + k / 16;
      return s * (i / s) + (i + n - (16 * i) / n) % s;
   endfunction

   initial begin
      ent_t e;
      forever begin
         @(negedge clock);
         if (!reset) begin
            stalled = 0;
            prev_v  = 0;
         end else begin
            if (stalled) begin
               chk("hold_data", out_data, hd);
               chk("hold_last", out_last, hl);
               chk("hold_mode", out_mode, hm);
            end
            if (out_valid && !prev_v) rise_cyc = cyc;
            prev_v    = out_valid;
            out_ready = ($urandom_range(99) < rdy_pct);
            if (out_valid && out_ready) begin
               if (expq.size() == 0) chk("extra_out", expq.size(), 1);
               else begin
                  e = expq.pop_front();
                  chk("out_data", out_data, e.d);
                  chk("out_last", out_last, e.l);
                  chk("out_mode", out_mode, e.m);
               end
               cap.push_back(int'(out_data));
               if (out_last) lastcyc.push_back(cyc);
               nout++;
            end
            stalled = out_valid && !out_ready;
            hd = out_data;
            hl = out_last;
            hm = out_mode;
         end
      end
   end

   task automatic send_bit(input logic [W-1:0] d, input logic [1:0] m, input int gap);
      int t = 0;
      do begin
         @(negedge clock);
         in_data  = d;
         mode     = m;
         in_valid = ($urandom_range(99) >= gap);
         t++;
      end while (!(in_valid && in_ready) && t < 5000);
      if (t >= 5000) chk("in_timeout", t, 0);
      acc_cyc = cyc + 1;
   endtask

   task automatic send_sym(input logic [1:0] m, input bit idx, input int gap, input int cnt);
      logic [W-1:0] rx [288];
      ent_t e;
      int n = 48 * (m == 0 ? 1 : m == 1 ? 2 : m == 2 ? 4 : 6);
      for (int j = 0; j < n; j++) rx[j] = idx ? W'(j) : W'($urandom);
      if (cnt == n)
         for (int k = 0; k < n; k++) begin
            e.d = rx[perm(int'(m), k)];
            e.l = (k == n - 1);
            e.m = m;
            expq.push_back(e);
         end
      for (int j = 0; j < cnt; j++)
         send_bit(rx[j], j == 0 ? m : 2'($urandom_range(3)), gap);
   endtask

   task automatic idle();
      @(negedge clock);
      in_valid = 0;
   endtask

   task automatic wait_drain();
      int t = 0;
      idle();
      while ((expq.size() != 0 || out_valid) && t < 20000) begin
         @(negedge clock);
         t++;
      end
      if (t >= 20000) chk("drain_timeout", expq.size(), 0);
   endtask

   initial begin
      int n0, rc, t;
      #12;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_mode", out_mode, 0);
      @(negedge clock);
      reset = 1;
      @(negedge clock);
      chk("rel_in_ready", in_ready, 1);

      rdy_pct = 100;
      cap.delete();
      send_sym(2'd0, 1, 0, 48);
      wait_drain();
      chk("t1_latency", rise_cyc, acc_cyc + 3);
      chk("t1_count", cap.size(), 48);
      if (cap.size() == 48) begin
         chk("t1_k1", cap[1], 3);
         chk("t1_k16", cap[16], 1);
         chk("t1_k47", cap[47], 47);
      end

      cap.delete();
      send_sym(2'd3, 1, 0, 288);
      wait_drain();
      chk("t2_latency", rise_cyc, acc_cyc + 3);
      chk("t2_count", cap.size(), 288);
      if (cap.size() == 288) begin
         chk("t2_k0", cap[0], 0);
         chk("t2_k1", cap[1], 20);
         chk("t2_k2", cap[2], 37);
         chk("t2_k3", cap[3], 54);
      end

      cap.delete();
      lastcyc.delete();
      send_sym(2'd2, 1, 0, 192);
      send_sym(2'd1, 1, 0, 96);
      idle();
      chk("t3_ready_low", in_ready, 0);
      t = 0;
      while (!in_ready && t < 5000) begin
         @(negedge clock);
         t++;
      end
      rc = cyc;
      wait_drain();
      chk("t3_lasts", lastcyc.size(), 2);
      if (lastcyc.size() == 2) begin
         chk("t3_no_gap", lastcyc[1] - lastcyc[0], 96);
         chk("t3_ready_back", rc, lastcyc[0] + 1);
      end
      if (cap.size() == 288) begin
         chk("t3_s1_k1", cap[1], 13);
         chk("t3_s2_k1", cap[193], 6);
      end

      rdy_pct = 50;
      n0 = nout;
      begin
         int tot = 0;
         for (int s = 0; s < 10; s++) begin
            logic [1:0] m = 2'($urandom_range(3));
            tot += 48 * (m == 0 ? 1 : m == 1 ? 2 : m == 2 ? 4 : 6);
            send_sym(m, 0, 30, 48 * (m == 0 ? 1 : m == 1 ? 2 : m == 2 ? 4 : 6));
         end
         wait_drain();
         chk("t4_count", nout - n0, tot);
      end

      rdy_pct = 100;
      cap.delete();
      send_sym(2'd0, 0, 20, 20);
      @(negedge clock);
      flush    = 1;
      in_valid = 1;
      in_data  = '1;
      mode     = 2'd3;
      @(negedge clock);
      flush    = 0;
      in_valid = 0;
      send_sym(2'd0, 1, 0, 48);
      wait_drain();
      chk("t5_count", cap.size(), 48);
      if (cap.size() == 48) chk("t5_k1", cap[1], 3);

      n0 = nout;
      send_sym(2'd3, 1, 0, 288);
      idle();
      t = 0;
      while (nout - n0 < 100 && t < 5000) begin
         @(posedge clock);
         t++;
      end
      chk("t6_reach_k100", nout - n0 >= 100, 1);
      #1;
      reset = 0;
      expq.delete();
      #1;
      chk("t6_async_valid", out_valid, 0);
      chk("t6_async_last", out_last, 0);
      chk("t6_async_mode", out_mode, 0);
      repeat (3) @(negedge clock);
      chk("t6_ready_rst", in_ready, 0);
      reset = 1;
      cap.delete();
      send_sym(2'd3, 1, 0, 288);
      wait_drain();
      chk("t6_count", cap.size(), 288);
      if (cap.size() == 288) begin
         chk("t6_k0", cap[0], 0);
         chk("t6_k1", cap[1], 20);
         chk("t6_k3", cap[3], 54);
      end

      repeat (4) @(negedge clock);
      chk("end_idle", out_valid, 0);
      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end
endmodule
